// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file and its load scoreboard.
// Optional parity storage is enabled by defining REGFILE_PARITY_EN.
package regfile_mp_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int NRD_DEF   = 2;

  // x0 is hardwired to zero; it is never written and never marked busy
  localparam int X0_ADDR = 0;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback-side bundle of the register file: read ports, both write
// ports, load allocation, and the status outputs.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);

  logic [NRD*AW-1:0]   i_rd_addr;
  logic [NRD-1:0]      i_rd_en;
  logic [NRD*XLEN-1:0] o_rd_data;
  logic [NRD-1:0]      o_rd_busy;

  logic                i_w0_en;
  logic [AW-1:0]       i_w0_addr;
  logic [XLEN-1:0]     i_w0_data;

  logic                i_w1_en;
  logic [AW-1:0]       i_w1_addr;
  logic [XLEN-1:0]     i_w1_data;

  logic                i_alloc_en;
  logic [AW-1:0]       i_alloc_addr;

  logic [AW:0]         o_pending_cnt;
  logic                o_par_err;
  logic [AW-1:0]       o_par_err_addr;

  modport master (
    output i_rd_addr, i_rd_en,
    output i_w0_en, i_w0_addr, i_w0_data,
    output i_w1_en, i_w1_addr, i_w1_data,
    output i_alloc_en, i_alloc_addr,
    input  o_rd_data, o_rd_busy, o_pending_cnt, o_par_err, o_par_err_addr
  );

  modport slave (
    input  i_rd_addr, i_rd_en,
    input  i_w0_en, i_w0_addr, i_w0_data,
    input  i_w1_en, i_w1_addr, i_w1_data,
    input  i_alloc_en, i_alloc_addr,
    output o_rd_data, o_rd_busy, o_pending_cnt, o_par_err, o_par_err_addr
  );

endinterface

// File: rtl/regfile_mp_sb_rf_scoreboard.sv
// Busy-bit scoreboard for outstanding loads: alloc sets, load return clears,
// and a registered count of busy registers kept in step with the vector.
module rf_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_alloc_en,
  input  logic [AW-1:0]    i_alloc_addr,
  input  logic             i_w1_en,
  input  logic [AW-1:0]    i_w1_addr,
  output logic [NREGS-1:0] o_busy,
  output logic [AW:0]      o_pending_cnt
);

  logic [NREGS-1:0] busy_reg, busy_next;
  logic [AW:0]      cnt_reg, cnt_next;
  logic             alloc_ok;
  logic             set_new;
  logic             clr_old;

  always_comb begin
    alloc_ok = i_alloc_en && (i_alloc_addr != AW'(X0_ADDR));
    // Only real 0->1 / 1->0 transitions move the count; a same-cycle
    // alloc of the returning register keeps it busy, so nothing clears.
    set_new  = alloc_ok && !busy_reg[i_alloc_addr];
    clr_old  = i_w1_en && busy_reg[i_w1_addr] &&
               !(alloc_ok && (i_alloc_addr == i_w1_addr));

    busy_next = busy_reg;
    if (i_w1_en) begin
      busy_next[i_w1_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_next[i_alloc_addr] = 1'b1;
    end

    cnt_next = cnt_reg;
    case ({set_new, clr_old})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign o_busy        = busy_reg;
  assign o_pending_cnt = cnt_reg;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with W0/W1 write bypass and a load scoreboard.
// Define REGFILE_PARITY_EN to store per-entry even parity and flag read errors.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  regfile_mp_sb_if.slave  bus
);

  logic [XLEN-1:0]     mem_reg [NREGS];
  logic [NREGS-1:0]    busy_vec;
  logic [NRD*XLEN-1:0] rd_data_flat;
  logic [NRD-1:0]      rd_busy_flat;
  logic                w0_ok;
  logic                w1_ok;

  assign w0_ok = bus.i_w0_en && (bus.i_w0_addr != AW'(X0_ADDR));
  assign w1_ok = bus.i_w1_en && (bus.i_w1_addr != AW'(X0_ADDR));

  // W0 is the younger instruction, so its write is issued last and wins a collision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (w1_ok) begin
        mem_reg[bus.i_w1_addr] <= bus.i_w1_data;
      end
      if (w0_ok) begin
        mem_reg[bus.i_w0_addr] <= bus.i_w0_data;
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_alloc_en    (bus.i_alloc_en),
    .i_alloc_addr  (bus.i_alloc_addr),
    .i_w1_en       (bus.i_w1_en),
    .i_w1_addr     (bus.i_w1_addr),
    .o_busy        (busy_vec),
    .o_pending_cnt (bus.o_pending_cnt)
  );

`ifdef REGFILE_PARITY_EN
  logic            par_reg [NREGS];
  logic [NRD-1:0]  par_fail;
  logic            par_err_reg;
  logic [AW-1:0]   par_err_addr_reg;
  logic            any_fail;
  logic [AW-1:0]   fail_addr;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            is_x0;
      logic            w0_hit;
      logic            w1_hit;
      logic [XLEN-1:0] data;

      assign addr   = bus.i_rd_addr[gi*AW +: AW];
      assign is_x0  = (addr == AW'(X0_ADDR));
      assign w0_hit = bus.i_w0_en && (bus.i_w0_addr == addr);
      assign w1_hit = bus.i_w1_en && (bus.i_w1_addr == addr);

      always_comb begin
        data = mem_reg[addr];
        if (is_x0) begin
          data = '0;
        end else if (w0_hit) begin
          data = bus.i_w0_data;
        end else if (w1_hit) begin
          data = bus.i_w1_data;
        end
      end

      assign rd_data_flat[gi*XLEN +: XLEN] = data;
      // The load returning this cycle already supplies the data, so no stall
      assign rd_busy_flat[gi] = bus.i_rd_en[gi] & busy_vec[addr] & ~w1_hit;

`ifdef REGFILE_PARITY_EN
      assign par_fail[gi] = bus.i_rd_en[gi] & ~is_x0 & ~w0_hit & ~w1_hit &
                            ((^mem_reg[addr]) != par_reg[addr]);
`endif
    end
  endgenerate

  assign bus.o_rd_data = rd_data_flat;
  assign bus.o_rd_busy = rd_busy_flat;

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        par_reg[i] <= 1'b0;
      end
    end else begin
      if (w1_ok) begin
        par_reg[bus.i_w1_addr] <= ^bus.i_w1_data;
      end
      if (w0_ok) begin
        par_reg[bus.i_w0_addr] <= ^bus.i_w0_data;
      end
    end
  end

  // Scan high to low so the lowest failing port is the one captured
  always_comb begin
    any_fail  = 1'b0;
    fail_addr = '0;
    for (int k = NRD - 1; k >= 0; k--) begin
      if (par_fail[k]) begin
        any_fail  = 1'b1;
        fail_addr = bus.i_rd_addr[k*AW +: AW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      par_err_reg      <= 1'b0;
      par_err_addr_reg <= '0;
    end else if (!par_err_reg && any_fail) begin
      par_err_reg      <= 1'b1;
      par_err_addr_reg <= fail_addr;
    end
  end

  assign bus.o_par_err      = par_err_reg;
  assign bus.o_par_err_addr = par_err_addr_reg;
`else
  assign bus.o_par_err      = 1'b0;
  assign bus.o_par_err_addr = '0;
`endif

endmodule
